chan13_14_latch: RTL



---
 rtl/chan_io_pkg.sv | 22 ++
 rtl/chan13_14_latch_cdu_drive_pacer.sv | 38 +++
 rtl/chan13_14_latch.sv | 107 ++++++++++
 3 files changed

// File: rtl/chan_io_pkg.sv
// Shared constants, axis enumeration and axis-to-bit mapping for the channel 13/14 I/O slice.
package chan_io_pkg;

    localparam int CHAN_W    = 15;
    localparam int BIT16_IDX = 14;
    localparam int NAXIS_DEF = 5;
    localparam int PACE_DEF  = 4;

    typedef enum logic [2:0] {
        AX_X = 3'd0,
        AX_Y = 3'd1,
        AX_Z = 3'd2,
        AX_T = 3'd3,
        AX_S = 3'd4
    } axis_e;

    // Axis X sits on the top packed bit (channel bit 16); later axes walk downward.
    function automatic int axis_bit(input int a);
        return BIT16_IDX - a;
    endfunction

endpackage

// File: rtl/chan13_14_latch_cdu_drive_pacer.sv
// One CDU drive axis: counts strobe events while enabled and emits a one-cycle pulse every PACE events.
module cdu_drive_pacer #(
    parameter int PACE = 4
) (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    input  logic i_enable,
    input  logic i_stb_evt,
    output logic o_pulse
);
    localparam int CW = (PACE > 1) ? $clog2(PACE) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (!i_enable) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (i_stb_evt) begin
            if (r_cnt == CW'(PACE - 1)) begin
                r_cnt   <= '0;
                r_pulse <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_pulse <= 1'b0;
            end
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/chan13_14_latch.sv
// Output channels 13/14: write/clear latches, active-low read bus, paced CDU drive pulses.
// Optional odd-parity checking with sticky PARERR when CHAN_PARITY_EN is defined.
module chan13_14_latch
    import chan_io_pkg::*;
#(
    parameter int NAXIS = NAXIS_DEF,
    parameter int PACE  = PACE_DEF
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic [CHAN_W-1:0] CHWL_n,
    input  logic              WCH13_n,
    input  logic              WCH14_n,
    input  logic              CCH13,
    input  logic              CCH14,
    input  logic              RCH13_n,
    input  logic              RCH14_n,
    input  logic              CDUSTB_n,
    output logic [CHAN_W-1:0] CHOR_n,
    output logic [CHAN_W-1:0] CH13,
    output logic [CHAN_W-1:0] CH14,
    output logic [NAXIS-1:0]  CDUDRV,
    output logic              DRVBUSY
`ifdef CHAN_PARITY_EN
    ,
    output logic              PARERR
`endif
);
    logic [CHAN_W-1:0] r_ch13, r_ch14;
    logic [CHAN_W-1:0] w_ch13_d, w_ch14_d;
    logic              r_stb_prev;
    logic              r_drvbusy;
    logic              w_stb_evt;
    logic [NAXIS-1:0]  w_axis_en;

    always_comb begin
        w_ch13_d = r_ch13;
        if (CCH13)         w_ch13_d = '0;
        else if (!WCH13_n) w_ch13_d = ~CHWL_n;
        w_ch14_d = r_ch14;
        if (CCH14)         w_ch14_d = '0;
        else if (!WCH14_n) w_ch14_d = ~CHWL_n;
    end

    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            r_ch13     <= '0;
            r_ch14     <= '0;
            r_stb_prev <= 1'b1;
            r_drvbusy  <= 1'b0;
        end else begin
            r_ch13     <= w_ch13_d;
            r_ch14     <= w_ch14_d;
            r_stb_prev <= CDUSTB_n;
            r_drvbusy  <= |r_ch14[BIT16_IDX -: NAXIS];
        end
    end

    assign w_stb_evt = r_stb_prev & ~CDUSTB_n;

    // Enable needs both the stored bit and its next value: a write that sets the bit
    // misses the coincident strobe, and a clear/rewrite aborts even on the terminal strobe.
    genvar a;
    generate
        for (a = 0; a < NAXIS; a++) begin : g_axis
            localparam int B = axis_bit(a);
            assign w_axis_en[a] = r_ch14[B] & w_ch14_d[B];
            cdu_drive_pacer #(.PACE(PACE)) u_pacer (
                .SIM_CLK   (SIM_CLK),
                .SIM_RST   (SIM_RST),
                .i_enable  (w_axis_en[a]),
                .i_stb_evt (w_stb_evt),
                .o_pulse   (CDUDRV[a])
            );
        end
    endgenerate

`ifdef CHAN_PARITY_EN
    logic r_par13, r_par14, r_perr13, r_perr14;

    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            r_par13  <= 1'b1;
            r_par14  <= 1'b1;
            r_perr13 <= 1'b0;
            r_perr14 <= 1'b0;
        end else begin
            if (CCH13)         r_par13 <= 1'b1;
            else if (!WCH13_n) r_par13 <= ~(^(~CHWL_n));
            if (CCH14)         r_par14 <= 1'b1;
            else if (!WCH14_n) r_par14 <= ~(^(~CHWL_n));
            if (CCH13)                      r_perr13 <= 1'b0;
            else if (!(^{r_ch13, r_par13})) r_perr13 <= 1'b1;
            if (CCH14)                      r_perr14 <= 1'b0;
            else if (!(^{r_ch14, r_par14})) r_perr14 <= 1'b1;
        end
    end

    assign PARERR = r_perr13 | r_perr14;
`endif

    assign CH13    = r_ch13;
    assign CH14    = r_ch14;
    assign DRVBUSY = r_drvbusy;
    assign CHOR_n  = ~((RCH13_n ? '0 : r_ch13) | (RCH14_n ? '0 : r_ch14));

endmodule
